// File: rtl/idex_issue_buffer_pkg.sv
// ============================================================================
// Module  : pipe_pkg
// Brief   : Shared widths, control bit positions and the ID/EX bundle type.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package pipe_pkg;

    localparam int PIPE_DW    = 32;
    localparam int PIPE_RW    = 5;
    localparam int WB_W       = 2;
    localparam int M_W        = 3;
    localparam int EX_W       = 4;
    localparam int M_BRANCH   = 2;
    localparam int M_MEMREAD  = 1;
    localparam int M_MEMWRITE = 0;
    localparam int EX_REGDST  = 3;
    localparam int EX_ALUSRC  = 0;
    localparam int BUNDLE_W   = WB_W + M_W + EX_W + 4*PIPE_DW + 2*PIPE_RW;

    typedef struct packed {
        logic [WB_W-1:0]    wb;
        logic [M_W-1:0]     m;
        logic [EX_W-1:0]    ex;
        logic [PIPE_DW-1:0] npc;
        logic [PIPE_DW-1:0] rdata1;
        logic [PIPE_DW-1:0] rdata2;
        logic [PIPE_DW-1:0] sext;
        logic [PIPE_RW-1:0] rt;
        logic [PIPE_RW-1:0] rd;
    } idex_bundle_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_state_t;

    // A buffered load whose destination feeds the instruction now in IF/ID.
    function automatic logic load_use_hit(input idex_bundle_t e,
                                          input logic [PIPE_RW-1:0] rs,
                                          input logic [PIPE_RW-1:0] rt);
        return e.m[M_MEMREAD] && (e.rt != '0) && ((e.rt == rs) || (e.rt == rt));
    endfunction

endpackage

`default_nettype wire

// File: rtl/idex_issue_buffer_if.sv
// ============================================================================
// Module  : idex_issue_buffer_if
// Brief   : Decode-side and EX-side signals of the ID/EX issue buffer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface idex_issue_buffer_if #(
    parameter int DW = 32,
    parameter int RW = 5
);
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    ctlwb_in;
    logic [2:0]    ctlm_in;
    logic [3:0]    ctlex_in;
    logic [DW-1:0] npc_in;
    logic [DW-1:0] rdata1_in;
    logic [DW-1:0] rdata2_in;
    logic [DW-1:0] sext_in;
    logic [RW-1:0] rt_in;
    logic [RW-1:0] rd_in;

    logic          out_valid;
    logic          out_ready;
    logic [1:0]    wb_ctlout;
    logic [2:0]    m_ctlout;
    logic          regdst;
    logic          alusrc;
    logic [1:0]    aluop;
    logic [DW-1:0] npcout;
    logic [DW-1:0] rdata1out;
    logic [DW-1:0] rdata2out;
    logic [DW-1:0] s_extendout;
    logic [RW-1:0] instrout_2016;
    logic [RW-1:0] instrout_1511;

    logic [RW-1:0] ifid_rs;
    logic [RW-1:0] ifid_rt;
    logic          load_use_stall;
    logic [1:0]    count;

    modport master (
        output in_valid, ctlwb_in, ctlm_in, ctlex_in, npc_in, rdata1_in,
               rdata2_in, sext_in, rt_in, rd_in, out_ready, ifid_rs, ifid_rt,
        input  in_ready, out_valid, wb_ctlout, m_ctlout, regdst, alusrc, aluop,
               npcout, rdata1out, rdata2out, s_extendout, instrout_2016,
               instrout_1511, load_use_stall, count
    );

    modport slave (
        input  in_valid, ctlwb_in, ctlm_in, ctlex_in, npc_in, rdata1_in,
               rdata2_in, sext_in, rt_in, rd_in, out_ready, ifid_rs, ifid_rt,
        output in_ready, out_valid, wb_ctlout, m_ctlout, regdst, alusrc, aluop,
               npcout, rdata1out, rdata2out, s_extendout, instrout_2016,
               instrout_1511, load_use_stall, count
    );
endinterface

`default_nettype wire

// File: rtl/idex_issue_buffer_entry_reg.sv
// ============================================================================
// Module  : idex_entry_reg
// Brief   : One bundle-wide storage entry with load enable and async clear.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module idex_entry_reg
    import pipe_pkg::*;
(
    input  wire logic         clk,
    input  wire logic         rst_n,
    input  wire logic         load,
    input  idex_bundle_t      d,
    output idex_bundle_t      q
);
    idex_bundle_t r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (load) begin
            r_q <= d;
        end
    end

    assign q = r_q;
endmodule

`default_nettype wire

// File: rtl/idex_issue_buffer.sv
// ============================================================================
// Module  : idex_issue_buffer
// Brief   : 2-entry skid buffer for the ID/EX bundle with load-use detection.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module idex_issue_buffer
    import pipe_pkg::*;
#(
    parameter int DW    = 32,
    parameter int RW    = 5,
    parameter int DEPTH = 2
) (
    input  wire logic            clk,
    input  wire logic            rst_n,
    input  wire logic            flush,
    idex_issue_buffer_if.slave   bus
);
    occ_state_t   r_state;
    occ_state_t   w_state_nxt;
    logic         r_in_ready;
    logic         w_push;
    logic         w_pop;
    logic         w_load_head;
    logic         w_load_tail;
    logic         w_head_from_tail;
    idex_bundle_t w_in;
    idex_bundle_t w_head_d;
    idex_bundle_t w_head;
    idex_bundle_t w_tail;

    always_comb begin
        w_in        = '0;
        w_in.wb     = bus.ctlwb_in;
        w_in.m      = bus.ctlm_in;
        w_in.ex     = bus.ctlex_in;
        w_in.npc    = bus.npc_in[DW-1:0];
        w_in.rdata1 = bus.rdata1_in[DW-1:0];
        w_in.rdata2 = bus.rdata2_in[DW-1:0];
        w_in.sext   = bus.sext_in[DW-1:0];
        w_in.rt     = bus.rt_in[RW-1:0];
        w_in.rd     = bus.rd_in[RW-1:0];
    end

    assign w_push = bus.in_valid & r_in_ready;
    assign w_pop  = (r_state != EMPTY) & bus.out_ready;

    // Flush wins over everything; no entry is written on a flush cycle.
    always_comb begin
        w_state_nxt      = r_state;
        w_load_head      = 1'b0;
        w_load_tail      = 1'b0;
        w_head_from_tail = 1'b0;
        if (flush) begin
            w_state_nxt = EMPTY;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_push) begin
                        w_state_nxt = ONE;
                        w_load_head = 1'b1;
                    end
                end
                ONE: begin
                    if (w_push && w_pop) begin
                        w_load_head = 1'b1;
                    end else if (w_push) begin
                        w_state_nxt = TWO;
                        w_load_tail = 1'b1;
                    end else if (w_pop) begin
                        w_state_nxt = EMPTY;
                    end
                end
                TWO: begin
                    if (w_pop) begin
                        w_state_nxt      = ONE;
                        w_load_head      = 1'b1;
                        w_head_from_tail = 1'b1;
                    end
                end
                default: w_state_nxt = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= EMPTY;
            r_in_ready <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_in_ready <= (32'(w_state_nxt) < DEPTH);
        end
    end

    assign w_head_d = w_head_from_tail ? w_tail : w_in;

    idex_entry_reg u_head (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (w_load_head),
        .d     (w_head_d),
        .q     (w_head)
    );

    idex_entry_reg u_tail (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (w_load_tail),
        .d     (w_in),
        .q     (w_tail)
    );

    assign bus.in_ready       = r_in_ready;
    assign bus.out_valid      = (r_state != EMPTY);
    assign bus.count          = r_state;
    assign bus.wb_ctlout      = w_head.wb;
    assign bus.m_ctlout       = w_head.m;
    assign bus.regdst         = w_head.ex[EX_REGDST];
    assign bus.aluop          = w_head.ex[2:1];
    assign bus.alusrc         = w_head.ex[EX_ALUSRC];
    assign bus.npcout         = w_head.npc;
    assign bus.rdata1out      = w_head.rdata1;
    assign bus.rdata2out      = w_head.rdata2;
    assign bus.s_extendout    = w_head.sext;
    assign bus.instrout_2016  = w_head.rt;
    assign bus.instrout_1511  = w_head.rd;

    assign bus.load_use_stall = !flush && (
        ((r_state != EMPTY) && load_use_hit(w_head, bus.ifid_rs, bus.ifid_rt)) ||
        ((r_state == TWO)   && load_use_hit(w_tail, bus.ifid_rs, bus.ifid_rt)));
endmodule

`default_nettype wire
